pattern_seq_ctrl: RTL and testbench
===================================

PATTERN_SEQ_CTRL -- requirements
Module: pattern_seq_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: width of the length, remaining and match counters.
REQ-002 The block SHALL have parameter TIMEOUT, default 15: consecutive no-valid cycles in RUN before abort; 0 disables the timeout.
REQ-003 The block SHALL have port CLK  input  1  single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  one-cycle job request, honoured only in IDLE.
REQ-006 The block SHALL have port len  input  CNT_W  number of samples in the job, sampled with start.
REQ-007 The block SHALL have port s_valid  input  1  sample-stream valid.
REQ-008 The block SHALL have port s_a  input  1  sample bit a.
REQ-009 The block SHALL have port s_b  input  1  sample bit b.
REQ-010 The block SHALL have port s_ready  output  1  sample-stream ready, high only in RUN.
REQ-011 The block SHALL have port busy  output  1  high in RUN and FINISH.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse in FINISH.
REQ-013 The block SHALL have port aborted  output  1  high with done when the job ended by timeout.
REQ-014 The block SHALL have port match_cnt  output  CNT_W  matches found in the current or last job.

Function
REQ-015 Control FSM SHALL have states IDLE, RUN, FINISH.
REQ-016 IDLE with start=1 SHALL latch len into remaining, clear match_cnt and aborted, and reset the detector to D0.
REQ-017 From IDLE, start=1 with len!=0 SHALL go to RUN; with len=0 SHALL go straight to FINISH.
REQ-018 start SHALL be ignored in RUN and FINISH.
REQ-019 A sample SHALL be accepted only on a cycle with s_valid=1 and s_ready=1.
REQ-020 The detector SHALL advance only on accepted samples: D0 goes to D1 if a=1, else stays in D0.
REQ-021 The detector SHALL go from D1 to D2 if b=1, else to D0.
REQ-022 The detector SHALL go from D2 to D0 unconditionally, ignoring a and b.
REQ-023 Each accepted sample that moves the detector D1->D2 SHALL increment match_cnt by 1; overflow is impossible (at most len/2 matches).
REQ-024 Each accepted sample SHALL decrement remaining; accepting the sample with remaining=1 SHALL move the FSM to FINISH on the next edge.
REQ-025 An idle counter SHALL clear on entering RUN and on each accept, and SHALL increment on each RUN cycle with s_valid=0.
REQ-026 With TIMEOUT!=0, the FSM SHALL move to FINISH and set aborted=1 on the next edge when the idle counter reaches TIMEOUT.
REQ-027 FINISH SHALL last exactly one cycle with done=1, s_ready=0, and SHALL return to IDLE.
REQ-028 match_cnt and aborted SHALL hold their values in IDLE until the next honoured start.
REQ-029 Latency: s_ready SHALL rise the cycle after start; done SHALL rise the cycle after the last accept.

Reset
REQ-030 reset=1 at a rising CLK edge SHALL force state IDLE, detector D0, and all counters 0, from any state including mid-job.
REQ-031 reset SHALL force outputs s_ready=0, busy=0, done=0, aborted=0, match_cnt=0, and SHALL take priority over start.

Verification
REQ-032 len=4, samples (a,b)=(1,0),(0,1),(0,0),(0,0) -> match_cnt=1, done one cycle after 4th accept, aborted=0.
REQ-033 len=3, samples (1,0),(1,1),(1,1) -> match_cnt=1 (third sample consumed by D2->D0), done, aborted=0.
REQ-034 len=0 with start -> done=1 the next cycle, s_ready never high, match_cnt=0.
REQ-035 TIMEOUT=15, len=5, samples (1,0),(0,1), then s_valid=0 for 15 cycles -> FINISH next cycle, done=1, aborted=1, match_cnt=1.
REQ-036 reset asserted mid-RUN after 2 accepts -> next cycle s_ready=0, busy=0, match_cnt=0; a fresh start with len=2 then completes normally.
REQ-037 start pulsed with len=9 during RUN of a len=2 job -> ignored; done after 2 accepts.

Source files
------------

// File: rtl/pattern_seq_ctrl.sv
// Job controller that counts a-then-b patterns in a valid/ready sample stream.
// A job ends after len accepted samples or after a run of idle cycles (timeout).
module pattern_seq_ctrl #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             s_valid,
  input  logic             s_a,
  input  logic             s_b,
  output logic             s_ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  typedef enum logic [1:0] {D0, D1, D2} det_t;

  state_t             state, state_n;
  det_t               det, det_n;
  logic [CNT_W-1:0]   remaining, remaining_n;
  logic [IDLE_W-1:0]  idle_cnt, idle_cnt_n;
  logic [CNT_W-1:0]   match_n;
  logic               aborted_n;

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      det       <= D0;
      remaining <= '0;
      idle_cnt  <= '0;
      match_cnt <= '0;
      aborted   <= 1'b0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      det       <= det_n;
      remaining <= remaining_n;
      idle_cnt  <= idle_cnt_n;
      match_cnt <= match_n;
      aborted   <= aborted_n;
      s_ready   <= (state_n == RUN);
      busy      <= (state_n != IDLE);
      done      <= (state_n == FINISH);
    end
  end

  // Next-state logic; an accept in the timeout cycle wins over the abort
  always_comb begin
    state_n     = state;
    det_n       = det;
    remaining_n = remaining;
    idle_cnt_n  = idle_cnt;
    match_n     = match_cnt;
    aborted_n   = aborted;
    case (state)
      IDLE: begin
        if (start) begin
          remaining_n = len;
          match_n     = '0;
          aborted_n   = 1'b0;
          det_n       = D0;
          idle_cnt_n  = '0;
          state_n     = (len != '0) ? RUN : FINISH;
        end
      end
      RUN: begin
        if (s_valid) begin
          idle_cnt_n  = '0;
          remaining_n = remaining - CNT_W'(1);
          case (det)
            D0: det_n = s_a ? D1 : D0;
            D1: begin
              if (s_b) begin
                det_n   = D2;
                match_n = match_cnt + CNT_W'(1);
              end else begin
                det_n = D0;
              end
            end
            default: det_n = D0;
          endcase
          if (remaining == CNT_W'(1)) state_n = FINISH;
        end else if ((TIMEOUT != 0) && (idle_cnt == IDLE_W'(TIMEOUT))) begin
          state_n   = FINISH;
          aborted_n = 1'b1;
        end else begin
          idle_cnt_n = idle_cnt + IDLE_W'(1);
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Bench for pattern_seq_ctrl: directed scenarios plus random jobs, every cycle
// compared against a job-level model that scans the accepted samples for matches.
module tb_pattern_seq_ctrl;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TO    = 15;

  logic             CLK;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             s_valid;
  logic             s_a;
  logic             s_b;
  logic             s_ready;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] match_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: 0 = no job, 1 = taking samples, 2 = completion cycle
  int         m_phase = 0;
  int         m_left  = 0;
  int         m_quiet = 0;
  bit         m_abort = 0;
  logic [1:0] m_samp[$];

  pattern_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .reset(reset), .start(start), .len(len),
    .s_valid(s_valid), .s_a(s_a), .s_b(s_b),
    .s_ready(s_ready), .busy(busy), .done(done),
    .aborted(aborted), .match_cnt(match_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Pattern count: a=1 arms; the very next sample completes with b=1 and the
  // sample after a match is swallowed.
  function automatic int count_matches(input logic [1:0] q[$]);
    int i = 0;
    int m = 0;
    while (i < q.size()) begin
      if (q[i][1] && (i + 1 < q.size())) begin
        if (q[i+1][0]) begin
          m++;
          i += 3;
        end else begin
          i += 2;
        end
      end else begin
        i += 1;
      end
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_phase = 0; m_left = 0; m_quiet = 0; m_abort = 0;
      m_samp.delete();
    end else if (m_phase == 0) begin
      if (start) begin
        m_samp.delete();
        m_abort = 0;
        m_quiet = 0;
        m_left  = int'(len);
        m_phase = (len != 0) ? 1 : 2;
      end
    end else if (m_phase == 1) begin
      if (s_valid) begin
        m_samp.push_back({s_a, s_b});
        m_left--;
        m_quiet = 0;
        if (m_left == 0) m_phase = 2;
      end else if (TO != 0 && m_quiet == int'(TO)) begin
        m_phase = 2;
        m_abort = 1;
      end else begin
        m_quiet++;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check_all();
    chk("s_ready",   32'(s_ready),   32'(m_phase == 1));
    chk("busy",      32'(busy),      32'(m_phase != 0));
    chk("done",      32'(done),      32'(m_phase == 2));
    chk("aborted",   32'(aborted),   32'(m_abort));
    chk("match_cnt", 32'(match_cnt), 32'(count_matches(m_samp)));
  endtask

  // One clock: drive inputs, update model at the edge, compare at the falling edge
  task automatic cyc(input bit r, input bit st, input int l, input bit v, input bit a, input bit b);
    reset = r; start = st; len = CNT_W'(l); s_valid = v; s_a = a; s_b = b;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all();
  endtask

  task automatic nop();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int vprob;
    reset = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_a = 1'b0; s_b = 1'b0;
    @(negedge CLK);
    cyc(1, 1, 3, 1, 1, 1);
    chk("reset_ready", 32'(s_ready), 32'd0);
    chk("reset_match", 32'(match_cnt), 32'd0);
    nop();

    // len=4: (1,0),(0,1),(0,0),(0,0)
    cyc(0, 1, 4, 0, 0, 0);
    chk("lat_ready", 32'(s_ready), 32'd1);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("j4_done", 32'(done), 32'd1);
    chk("j4_match", 32'(match_cnt), 32'd1);
    chk("j4_abort", 32'(aborted), 32'd0);
    nop();
    chk("j4_hold", 32'(match_cnt), 32'd1);

    // len=3: third sample swallowed after the match
    cyc(0, 1, 3, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 1, 1);
    chk("j3_done", 32'(done), 32'd1);
    chk("j3_match", 32'(match_cnt), 32'd1);
    nop();

    // len=0 goes straight to the completion cycle
    cyc(0, 1, 0, 1, 1, 1);
    chk("j0_done", 32'(done), 32'd1);
    chk("j0_ready", 32'(s_ready), 32'd0);
    chk("j0_match", 32'(match_cnt), 32'd0);
    nop();

    // Timeout after 15 idle cycles
    cyc(0, 1, 5, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 15; i++) nop();
    chk("to_pre_done", 32'(done), 32'd0);
    nop();
    chk("to_done", 32'(done), 32'd1);
    chk("to_abort", 32'(aborted), 32'd1);
    chk("to_match", 32'(match_cnt), 32'd1);
    nop();
    chk("to_abort_hold", 32'(aborted), 32'd1);

    // Reset in the middle of a job, then a clean job
    cyc(0, 1, 5, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(1, 1, 2, 1, 1, 1);
    chk("mr_ready", 32'(s_ready), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_match", 32'(match_cnt), 32'd0);
    cyc(0, 1, 2, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 1);
    chk("mr_done", 32'(done), 32'd1);
    chk("mr_match2", 32'(match_cnt), 32'd1);
    nop();

    // start during RUN is ignored
    cyc(0, 1, 2, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 9, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 1);
    chk("ig_done", 32'(done), 32'd1);
    nop();
    chk("ig_busy", 32'(busy), 32'd0);

    // Random jobs with varying sample density, rare resets
    vprob = 70;
    for (int c = 0; c < 1500; c++) begin
      bit r;
      bit st;
      if (c % 150 == 0) begin
        case ($urandom_range(0, 2))
          0:       vprob = 70;
          1:       vprob = 30;
          default: vprob = 3;
        endcase
      end
      r  = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 3) == 0);
      cyc(r, st, int'($urandom_range(0, 7)), ($urandom_range(0, 99) < vprob),
          1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
